// File: rtl/sram_burst_reader.sv
// Burst read sequencer for a 1-cycle-latency SRAM bank, returning words on a
// valid/ready stream through a 2-entry skid buffer.
module sram_burst_reader #(
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_enable,
  output logic                  sram_write_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [WIDTH-1:0]      sram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_ptr;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [LEN_WIDTH-1:0]  issue_rem;
  logic [LEN_WIDTH-1:0]  beat_rem;
  logic [1:0]            cnt;
  logic                  inflight;
  logic [WIDTH-1:0]      buf0;
  logic [WIDTH-1:0]      buf1;
  logic [1:0]            occ;
  logic                  pop;
  logic                  issue;

  assign occ           = cnt + {1'b0, inflight};
  assign m_valid       = (cnt != 2'd0);
  assign pop           = m_valid & m_ready;
  assign m_data        = buf0;
  assign m_last        = m_valid && (beat_rem == LEN_WIDTH'(1));
  assign busy          = (state != IDLE);
  assign sram_write_en = 1'b0;

  // A read may only go out if its data is guaranteed a buffer slot on arrival.
  always_comb begin
    issue = 1'b0;
    if (state == ISSUE)
      issue = (occ < 2'd2) || ((occ == 2'd2) && pop);
  end

  assign sram_enable = issue;
  assign sram_addr   = issue ? addr_ptr : addr_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_ptr  <= '0;
      addr_hold <= '0;
      issue_rem <= '0;
      beat_rem  <= '0;
      cnt       <= '0;
      inflight  <= 1'b0;
      buf0      <= '0;
      buf1      <= '0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;

      if (issue) begin
        addr_hold <= addr_ptr;
        addr_ptr  <= addr_ptr + ADDR_WIDTH'(1);
        issue_rem <= issue_rem - LEN_WIDTH'(1);
      end

      if (pop)
        beat_rem <= beat_rem - LEN_WIDTH'(1);

      // buf0 is always the head; returning data lands in the first free slot.
      case ({inflight, pop})
        2'b10: begin
          if (cnt == 2'd0) buf0 <= sram_rdata;
          else             buf1 <= sram_rdata;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            buf0 <= sram_rdata;
          end else begin
            buf0 <= buf1;
            buf1 <= sram_rdata;
          end
        end
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              state     <= ISSUE;
              addr_ptr  <= base_addr;
              issue_rem <= length;
              beat_rem  <= length;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue && (issue_rem == LEN_WIDTH'(1)))
            state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Randomized bench for sram_burst_reader: a word-counting model predicts every
// bank access, beat, last flag and done pulse cycle by cycle.
module tb_sram_burst_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic        busy;
  logic        done;
  logic        sram_enable;
  logic        sram_write_en;
  logic [9:0]  sram_addr;
  logic [63:0] sram_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;

  logic [63:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  // model state
  int m_base, m_len, issued, popped, iss_prev, outst;
  bit m_act, done_due, chk_rst, mon_en, rnd_ready;
  bit exp_valid, exp_pop, exp_en, act_now;

  sram_burst_reader #(.WIDTH(64), .ADDR_WIDTH(10), .LEN_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .sram_enable(sram_enable), .sram_write_en(sram_write_en),
    .sram_addr(sram_addr), .sram_rdata(sram_rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial sram_rdata = '0;
  always @(posedge clk)
    if (sram_enable) sram_rdata <= mem[sram_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outstanding = issued - popped; a word issued in cycle k is poppable from k+2.
  always @(negedge clk) begin
    if (rst) begin
      m_act = 0; done_due = 0; chk_rst = 1;
      issued = 0; popped = 0; iss_prev = 0;
    end else if (mon_en) begin
      if (chk_rst) begin
        check("rst_busy",   64'(busy),        64'd0);
        check("rst_done",   64'(done),        64'd0);
        check("rst_en",     64'(sram_enable), 64'd0);
        check("rst_addr",   64'(sram_addr),   64'd0);
        check("rst_valid",  64'(m_valid),     64'd0);
        check("rst_last",   64'(m_last),      64'd0);
        check("rst_data",   m_data,           64'd0);
        chk_rst = 0;
      end
      act_now   = m_act;
      exp_valid = act_now && (iss_prev > popped);
      exp_pop   = exp_valid && m_ready;
      outst     = issued - popped;
      exp_en    = act_now && (issued < m_len) && (outst < 2 || (outst == 2 && exp_pop));

      check("busy",  64'(busy),          64'(act_now));
      check("done",  64'(done),          64'(done_due));
      check("wr_en", 64'(sram_write_en), 64'd0);
      check("en",    64'(sram_enable),   64'(exp_en));
      if (exp_en && sram_enable)
        check("addr", 64'(sram_addr), 64'((m_base + issued) % 1024));
      check("valid", 64'(m_valid), 64'(exp_valid));
      check("last",  64'(m_last),  64'(exp_valid && (popped == m_len - 1)));
      if (exp_valid && m_valid)
        check("data", m_data, mem[(m_base + popped) % 1024]);

      done_due = 0;
      iss_prev = issued;
      if (exp_en) issued++;
      if (exp_pop) begin
        popped++;
        if (popped == m_len) begin
          m_act = 0;
          done_due = 1;
        end
      end
      if (!act_now && start) begin
        m_base = int'(base_addr);
        m_len  = int'(length);
        issued = 0; popped = 0; iss_prev = 0;
        if (m_len == 0) done_due = 1;
        else            m_act = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic start_burst(input int b, input int l);
    base_addr = 10'(b);
    length    = 11'(l);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_act || done_due) && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 64'(m_act || done_due), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    m_ready = 1'b1; rnd_ready = 0; mon_en = 0;
    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1;
    tick();

    // basic burst, full throughput
    start_burst(12'h010, 4);
    wait_idle(50);

    // backpressure
    rnd_ready = 1;
    start_burst(12'h123, 8);
    wait_idle(200);

    // address wrap
    start_burst(12'h3FE, 4);
    wait_idle(100);
    rnd_ready = 0;

    // zero length
    start_burst(12'h055, 0);
    wait_idle(10);
    repeat (2) tick();

    // full-bank burst
    start_burst(0, 1024);
    wait_idle(1200);

    // start while busy is ignored
    rnd_ready = 1;
    start_burst(12'h100, 8);
    repeat (3) tick();
    start_burst(12'h200, 5);
    wait_idle(200);
    rnd_ready = 0;

    // reset mid-burst, then a fresh burst
    start_burst(12'h050, 8);
    begin
      int n = 0;
      while (popped < 3 && n < 50) begin
        tick();
        n++;
      end
      check("beats_before_rst", 64'(popped >= 3), 64'd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    start_burst(12'h060, 2);
    wait_idle(50);

    // random bursts
    repeat (12) begin
      rnd_ready = bit'($urandom_range(0, 1));
      start_burst(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)));
      wait_idle(300);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
